rr_port_arbiter: RTL and testbench
==================================

Name: rr_port_arbiter

Overview:
- Round-robin arbiter that shares one downstream valid/ready stream channel between NUM_REQ upstream requesters.
- Grants are per packet. A grant is held until the requester's last beat or until MAX_BURST beats have passed, whichever comes first.
- Sits in front of any shared single-port sink, for example a shared FIFO or bus master port.
- Adds one cycle of arbitration latency per grant. There is no data-path latency while a grant is held.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, payload width per beat
MAX_BURST, 8, maximum beats per grant (1..255); forces re-arbitration for fairness
SRC_W, $clog2(NUM_REQ), width of source index (derived, not overridable)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester beat valid
req_last  input  NUM_REQ  per-requester last beat of packet
req_data  input  NUM_REQ*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester ready
out_valid  output  1  downstream beat valid
out_data  output  DATA_W  downstream payload
out_last  output  1  downstream last; asserted for packet end or burst cut
out_ready  input  1  downstream ready
out_src  output  SRC_W  index of granted requester
busy  output  1  high while in GRANT state

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE, ptr=NUM_REQ-1, grant=0, beat_cnt=0.
- Output values in reset: out_valid=0, req_ready=0, out_last=0, out_src=0, busy=0, out_data=0.
- State IDLE:
  - All req_ready=0 and out_valid=0.
  - If any req_valid is high, select the first set bit searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - Register that index into grant, clear beat_cnt, and go to GRANT next cycle.
  - If no request is present, stay in IDLE.
- State GRANT (g=grant):
  - out_valid=req_valid[g] and out_data=req_data[g].
  - req_ready[g]=out_ready; all other req_ready=0.
  - out_src=g and busy=1.
- Handshake: a beat transfers when out_valid && out_ready. Each handshake increments beat_cnt (8-bit, saturating is not needed because the count is bounded by MAX_BURST).
- out_last = req_valid[g] && (req_last[g] || beat_cnt==MAX_BURST-1).
- Exit from GRANT happens on a handshake with out_last=1:
  - Next state is IDLE.
  - ptr updates to g, so g gets lowest priority next round.
  - A burst cut at MAX_BURST does not consume the requester's remaining beats; the requester re-arbitrates for them.
- If req_valid[g] drops while granted, the arbiter stays in GRANT with out_valid=0. There is no timeout and no grant revocation.
- Simultaneous requests in IDLE: only the round-robin winner is granted. The others wait and see req_ready=0.
- Back-to-back packets: there is always one IDLE cycle between grants, so peak throughput is MAX_BURST/(MAX_BURST+1).
- Reset asserted mid-burst: immediate return to reset values. Any partial packet is abandoned, and the sink must tolerate the truncated packet.
- req_data of non-granted requesters never reaches out_data.
- Requirements on requesters: hold req_valid, req_data and req_last stable until req_ready.

Test Plan:
- Reset then single request: req_valid=4'b0001 with a 3-beat packet (last on beat 3) and out_ready=1 -> out_valid rises 1 cycle after req_valid. out_src=0, beats pass on 3 consecutive cycles, out_last on beat 3, IDLE for 1 cycle, busy=0.
- All four requesting one-beat packets continuously -> grant order 0,1,2,3,0,1; each grant takes 2 cycles; no requester starves.
- MAX_BURST=8, requester 2 sends a 20-beat packet while requester 1 is also requesting -> 8 beats from src 2 with out_last on beat 8, then requester 1's packet, then src 2 resumes with its remaining 12 beats split 8+4.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-beat grant -> req_ready mirrors out_ready, beat_cnt advances only on handshakes, out_data is held stable and no beat is lost or duplicated.
- Granted requester deasserts valid for 5 cycles mid-packet -> out_valid=0 and busy=1 throughout, other requesters get no ready, and the packet resumes correctly.
- rst_n pulsed low during beat 2 of 4 -> all outputs return to 0 asynchronously, and after release the next grant starts from requester 0 priority.

Source files
------------

// File: rtl/rr_port_arbiter.sv
// Round-robin, packet-granular arbiter that shares one downstream
// valid/ready stream between NUM_REQ requesters. A grant lasts until the
// granted requester's last beat or until MAX_BURST beats have moved,
// whichever comes first. The winner then drops to lowest priority.
module rr_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8,
    localparam int SRC_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [SRC_W-1:0]          out_src,
    output logic                      busy
);

    // Beat index at which a grant is cut even without req_last.
    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arbState;

    arbState          stateReg;
    logic [SRC_W-1:0] ptrReg;      // most recently served requester
    logic [SRC_W-1:0] grantReg;    // requester currently owning the channel
    logic [7:0]       beatCntReg;  // beats moved under the current grant

    logic [DATA_W-1:0] reqWord [NUM_REQ];
    logic [SRC_W-1:0]  pickIdx;
    logic [SRC_W-1:0]  cand;
    logic              beatXfer;

    // Slice the flat payload bus into one word per requester.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : gSlice
            assign reqWord[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin pick: scan ptr+NUM_REQ down to ptr+1 so the candidate
    // closest after ptr is written last and therefore wins.
    always_comb begin
        pickIdx = '0;
        cand    = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = SRC_W'((int'(ptrReg) + off) % NUM_REQ);
            if (req_valid[cand]) begin
                pickIdx = cand;
            end
        end
    end

    // Pass-through of the granted requester; everything is quiet in IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_src   = '0;
        busy      = 1'b0;
        req_ready = '0;
        if (stateReg == GRANT) begin
            out_valid           = req_valid[grantReg];
            out_data            = reqWord[grantReg];
            out_last            = req_valid[grantReg] &&
                                  (req_last[grantReg] || beatCntReg == LAST_BEAT);
            out_src             = grantReg;
            busy                = 1'b1;
            req_ready[grantReg] = out_ready;
        end
    end

    assign beatXfer = out_valid && out_ready;

    // Arbitration state: latch a winner in IDLE, count beats in GRANT and
    // release on the final (or burst-cut) handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= IDLE;
            ptrReg     <= SRC_W'(NUM_REQ - 1);
            grantReg   <= '0;
            beatCntReg <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (|req_valid) begin
                        grantReg   <= pickIdx;
                        beatCntReg <= '0;
                        stateReg   <= GRANT;
                    end
                end
                GRANT: begin
                    if (beatXfer) begin
                        beatCntReg <= beatCntReg + 8'd1;
                        if (out_last) begin
                            stateReg <= IDLE;
                            ptrReg   <= grantReg;
                        end
                    end
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_port_arbiter.sv
// Scoreboard bench for rr_port_arbiter: each requester has a beat queue,
// expected downstream beats are queued as stimulus is loaded and popped on
// every downstream handshake.
module tb_rr_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [1:0]      out_src;
    logic            busy;

    always #5 clk = ~clk;

    rr_port_arbiter #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .MAX_BURST(MB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_last (req_last),
        .req_data (req_data),
        .req_ready(req_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last),
        .out_ready(out_ready),
        .out_src  (out_src),
        .busy     (busy)
    );

    logic [DW:0]   reqQ [N][$];   // {last, data} per requester
    logic [63:0]   expQ [$];      // {pad, src, last, data}
    logic [N-1:0]  hold;
    logic [N-1:0]  hsVec;
    int            passCnt = 0;
    int            checkCnt = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        if (obs === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] mkData(input int src, input int pkt, input int beat);
        return {8'(src), 8'(pkt), 16'(beat)};
    endfunction

    function automatic logic [63:0] mkExp(input int src, input int pkt, input int beat, input bit last);
        return {27'b0, 4'(src), last, mkData(src, pkt, beat)};
    endfunction

    task automatic loadPkt(input int src, input int pkt, input int nBeats);
        for (int b = 0; b < nBeats; b++)
            reqQ[src].push_back({(b == nBeats - 1), mkData(src, pkt, b)});
    endtask

    task automatic driveInputs();
        for (int i = 0; i < N; i++) begin
            if (reqQ[i].size() > 0 && !hold[i]) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = reqQ[i][0][DW];
                req_data[i*DW +: DW] = reqQ[i][0][DW-1:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
    endtask

    // One clock: monitor at the falling edge, update requesters after the rise.
    task automatic stepCycle();
        logic [63:0] obs;
        @(negedge clk);
        hsVec = req_valid & req_ready;
        obs = {27'b0, 2'b0, out_src, out_last, out_data};
        if (out_valid && out_ready) begin
            if (expQ.size() == 0) checkVal("unexpected beat", obs, '1);
            else checkVal("beat", obs, expQ.pop_front());
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (hsVec[i] && reqQ[i].size() > 0) void'(reqQ[i].pop_front());
        driveInputs();
        #1;
    endtask

    task automatic drain(input int budget, output int used);
        used = 0;
        while (expQ.size() > 0 && used < budget) begin
            stepCycle();
            used++;
        end
        checkVal("drain", 64'(expQ.size()), 64'(0));
    endtask

    task automatic clearStim();
        for (int i = 0; i < N; i++) reqQ[i].delete();
        expQ.delete();
        hold      = '0;
        out_ready = 1'b1;
        driveInputs();
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearStim();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic checkZero(input string tag);
        checkVal({tag, " out_valid"}, 64'(out_valid), 64'(0));
        checkVal({tag, " req_ready"}, 64'(req_ready), 64'(0));
        checkVal({tag, " out_last"},  64'(out_last),  64'(0));
        checkVal({tag, " out_src"},   64'(out_src),   64'(0));
        checkVal({tag, " busy"},      64'(busy),      64'(0));
        checkVal({tag, " out_data"},  64'(out_data),  64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        int guard;
        logic [5:0]    pat;
        logic [DW-1:0] prevData;

        clearStim();
        #1;
        checkZero("in reset");
        doReset();
        checkZero("after reset");

        // Single 3-beat packet from requester 0.
        loadPkt(0, 1, 3);
        for (int b = 0; b < 3; b++) expQ.push_back(mkExp(0, 1, b, b == 2));
        driveInputs();
        #1;
        checkVal("t1 arb cycle valid", 64'(out_valid), 64'(0));
        checkVal("t1 arb cycle busy",  64'(busy),      64'(0));
        stepCycle();
        checkVal("t1 valid", 64'(out_valid), 64'(1));
        checkVal("t1 src",   64'(out_src),   64'(0));
        checkVal("t1 busy",  64'(busy),      64'(1));
        checkVal("t1 last b1", 64'(out_last), 64'(0));
        stepCycle();
        stepCycle();
        checkVal("t1 last b3", 64'(out_last), 64'(1));
        stepCycle();
        checkVal("t1 gap busy",  64'(busy),      64'(0));
        checkVal("t1 gap valid", 64'(out_valid), 64'(0));
        checkVal("t1 drained",   64'(expQ.size()), 64'(0));

        // All four requesters with back-to-back one-beat packets.
        doReset();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < N; s++) begin
                loadPkt(s, p, 1);
                expQ.push_back(mkExp(s, p, 0, 1'b1));
            end
        driveInputs();
        #1;
        drain(40, used);
        checkVal("t2 cycles", 64'(used), 64'(16));

        // 20-beat packet from requester 2 cut into MAX_BURST pieces.
        doReset();
        loadPkt(2, 0, 20);
        driveInputs();
        #1;
        stepCycle();
        loadPkt(1, 0, 2);
        driveInputs();
        #1;
        for (int b = 0; b < 8; b++)   expQ.push_back(mkExp(2, 0, b, b == 7));
        for (int b = 0; b < 2; b++)   expQ.push_back(mkExp(1, 0, b, b == 1));
        for (int b = 8; b < 16; b++)  expQ.push_back(mkExp(2, 0, b, b == 15));
        for (int b = 16; b < 20; b++) expQ.push_back(mkExp(2, 0, b, b == 19));
        drain(100, used);
        checkVal("t3 cycles", 64'(used), 64'(25));

        // Backpressure during a 4-beat grant to requester 3.
        doReset();
        loadPkt(3, 0, 4);
        for (int b = 0; b < 4; b++) expQ.push_back(mkExp(3, 0, b, b == 3));
        driveInputs();
        #1;
        checkVal("t4 arb busy", 64'(busy), 64'(0));
        pat = 6'b111001;
        prevData = '0;
        for (int k = 0; k < 6; k++) begin
            stepCycle();
            out_ready = pat[k];
            #1;
            checkVal("t4 ready", 64'(req_ready), 64'({pat[k], 3'b000}));
            checkVal("t4 busy",  64'(busy),      64'(1));
            if (k > 0 && !pat[k-1]) checkVal("t4 data held", 64'(out_data), 64'(prevData));
            prevData = out_data;
        end
        stepCycle();
        out_ready = 1'b1;
        #1;
        checkVal("t4 end busy", 64'(busy), 64'(0));
        checkVal("t4 drained",  64'(expQ.size()), 64'(0));

        // Granted requester stalls for 5 cycles mid-packet.
        doReset();
        loadPkt(0, 0, 4);
        loadPkt(1, 0, 2);
        for (int b = 0; b < 4; b++) expQ.push_back(mkExp(0, 0, b, b == 3));
        for (int b = 0; b < 2; b++) expQ.push_back(mkExp(1, 0, b, b == 1));
        driveInputs();
        #1;
        guard = 0;
        while (reqQ[0].size() > 2 && guard < 20) begin
            stepCycle();
            guard++;
        end
        checkVal("t5 reach beat3", 64'(reqQ[0].size()), 64'(2));
        hold[0] = 1'b1;
        driveInputs();
        #1;
        for (int k = 0; k < 5; k++) begin
            checkVal("t5 stall valid", 64'(out_valid), 64'(0));
            checkVal("t5 stall busy",  64'(busy),      64'(1));
            checkVal("t5 stall others ready", 64'(req_ready[3:1]), 64'(0));
            stepCycle();
        end
        hold[0] = 1'b0;
        driveInputs();
        #1;
        drain(30, used);

        // Reset pulsed during beat 2 of 4; priority restarts at requester 0.
        doReset();
        loadPkt(0, 0, 1);
        expQ.push_back(mkExp(0, 0, 0, 1'b1));
        driveInputs();
        #1;
        drain(10, used);
        loadPkt(2, 1, 4);
        expQ.push_back(mkExp(2, 1, 0, 1'b0));
        driveInputs();
        #1;
        guard = 0;
        while (reqQ[2].size() > 3 && guard < 20) begin
            stepCycle();
            guard++;
        end
        checkVal("t6 reach beat2", 64'(reqQ[2].size()), 64'(3));
        #1;
        rst_n = 1'b0;
        #1;
        checkZero("mid-burst reset");
        clearStim();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #2;
        loadPkt(0, 2, 1);
        loadPkt(1, 2, 1);
        expQ.push_back(mkExp(0, 2, 0, 1'b1));
        expQ.push_back(mkExp(1, 2, 0, 1'b1));
        driveInputs();
        #1;
        drain(20, used);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
